// File: rtl/spi_pattern_gen.sv
// Frame pattern generator feeding the SPI transmit FIFO write side.
// Emits FRAME_LEN bytes counting up from FIRST_CHAR per frame.
module spi_pattern_gen #(
  parameter int              DATA       = 8,
  parameter int              FIFO_DEPTH = 16,
  parameter int              FRAME_LEN  = 9,
  parameter logic [DATA-1:0] FIRST_CHAR = 8'h31,
  parameter int              GAP        = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     frames,
  input  logic            stop,
  input  logic            inject_err,
  input  logic            full,
  output logic            wr,
  output logic [DATA-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [15:0]     frame_cnt
);

  if (FRAME_LEN < 1 || FRAME_LEN > 255 || FIFO_DEPTH < 1) begin : g_bad_param
    $error("spi_pattern_gen: illegal FRAME_LEN or FIFO_DEPTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [7:0]  LAST     = 8'(FRAME_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);

  state_t      state;
  state_t      state_d;
  logic [7:0]  idx;
  logic [15:0] frames_q;
  logic [15:0] gap_cnt;
  logic        err_q;
  logic        stop_q;
  logic        accept;
  logic        run_end;
  logic        bad_byte;

  assign accept  = (state == S_IDLE) && start;
  assign run_end = ((frames_q != '0) && (frame_cnt + 16'd1 == frames_q))
                   || stop_q || stop;

  // Corrupted frame repeats the previous byte in its last slot
  assign bad_byte = err_q && (frame_cnt == '0) && (idx == LAST);
  assign wdata    = FIRST_CHAR + DATA'(idx)
                    - (bad_byte ? DATA'(1) : DATA'(0));

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    wr      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_d = S_WRITE;
      end
      S_WRITE: begin
        wr = !full;
        if (wr && (idx == LAST)) begin
          if (run_end)      state_d = S_DONE;
          else if (GAP > 0) state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = S_WRITE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      frame_cnt <= '0;
      frames_q  <= '0;
      err_q     <= 1'b0;
      stop_q    <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      if (accept) begin
        frames_q  <= frames;
        err_q     <= inject_err;
        idx       <= '0;
        frame_cnt <= '0;
        stop_q    <= 1'b0;
      end else begin
        if (busy && stop) stop_q <= 1'b1;
        if (wr) begin
          if (idx == LAST) begin
            idx       <= '0;
            frame_cnt <= frame_cnt + 16'd1;
            err_q     <= 1'b0;
          end else begin
            idx <= idx + 8'd1;
          end
        end
      end
      gap_cnt <= (state == S_GAP) ? gap_cnt + 16'd1 : '0;
    end
  end

endmodule

// File: doc/spi_pattern_gen.md
# spi_pattern_gen

Frame pattern generator that writes the checker's expected byte sequence into the SPI transmit FIFO. Each frame is FRAME_LEN bytes counting up from FIRST_CHAR; with defaults this is ASCII "123456789", 0x31..0x39. The block sits on the write side of the FIFO whose read side feeds the link and the far-end checker. It provides a known-good stream, or a deliberately corrupted one, for link bring-up and loopback tests.

## Interface
- DATA, 8, byte width of FIFO write data
- FIFO_DEPTH, 16, depth of the downstream FIFO (informational; flow control uses `full` only)
- FRAME_LEN, 9, bytes per frame, legal range 1..255
- FIRST_CHAR, 8'h31, value of byte 0 of every frame
- GAP, 0, idle cycles between frames, 0 = back-to-back
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request to begin a run; ignored while busy
- frames  in  16  frames per run, sampled on accepted start; 0 = continuous until stop
- stop  in  1  level or pulse; finish the current frame, then end the run
- inject_err  in  1  sampled on accepted start; corrupts the last byte of the run's first frame
- full  in  1  FIFO full; a write is not allowed while high
- wr  out  1  FIFO write strobe; a write occurs on every clk edge where wr=1
- wdata  out  DATA  FIFO write data, valid when wr=1
- busy  out  1  high from the cycle after accepted start until run end
- done  out  1  one-cycle pulse when a run ends
- frame_cnt  out  16  frames completed in the current or last run; cleared on accepted start

## Operation
- FSM states and transitions:
  - IDLE: accepted start (state==IDLE && start) -> WRITE. Latch frames_q, latch err_q=inject_err, clear idx, frame_cnt, stop_q.
  - WRITE: wr = !full, combinational from state and full.
    - Each write increments idx.
    - Write of byte FRAME_LEN-1 ends the frame: frame_cnt+1, idx->0.
    - After frame end: if run complete -> DONE; else if GAP>0 -> GAP; else stay in WRITE.
    - Run complete means (frames_q!=0 && frame_cnt+1==frames_q) or stop_q or stop.
  - GAP: count GAP cycles with wr=0, then -> WRITE.
  - DONE: done=1 for one cycle, -> IDLE.
- wdata = FIRST_CHAR + idx, truncated to DATA bits (wraps mod 2^DATA).
  - Exception: if err_q and frame_cnt==0 and idx==FRAME_LEN-1, wdata = FIRST_CHAR + idx - 1, i.e. the previous byte is repeated.
  - err_q clears after that write.
- stop is latched (stop_q) while busy. It never truncates a frame. stop in IDLE has no effect.
- Stall: while full=1 in WRITE, wr=0. idx and wdata hold.
- frame_cnt wraps 0xFFFF->0 in continuous mode. Wrap does not end the run.
- start while busy or in DONE: ignored, no state change.

## Timing
- Reset values: wr=0, busy=0, done=0, frame_cnt=0, wdata=FIRST_CHAR (idx=0), state IDLE.
- rst mid-run: next cycle all outputs at reset values. The partial frame is abandoned, no done pulse.
- Latency: start accepted at edge N. busy=1 and the first write is possible at edge N+1 (wr=1 during cycle N+1 if full=0).
- Throughput: one byte per cycle with full=0. One frame takes FRAME_LEN cycles plus GAP idle cycles.
- full is sampled combinationally the same cycle. Deasserting full lets a write occur in that same cycle.
- Run end:
  - Last write at edge M.
  - DONE is the state during cycle M+1: done=1, busy still 1.
  - IDLE from cycle M+2: busy=0. start is accepted from cycle M+2.

## Test plan
- Defaults, frames=1, full=0, pulse start: wr high 9 consecutive cycles, wdata 0x31..0x39, done pulses 1 cycle later, frame_cnt=1, busy low next cycle.
- frames=3, GAP=2: 27 writes in three 9-byte bursts separated by exactly 2 wr=0 cycles, frame_cnt ends at 3, single done.
- full toggled pseudo-randomly during frames=2: writes only when full=0, byte sequence intact (0x31..0x39 twice), no duplicates or drops.
- inject_err=1 with start, frames=2: first frame ends 0x38,0x38. Second frame is the clean 0x31..0x39.
- frames=0, assert stop at idx=4 of frame 5: frame 5 completes through 0x39, no further writes, frame_cnt=5, done pulses.
- rst asserted mid-frame (idx=6): next cycle wr=0, busy=0, wdata=0x31, frame_cnt=0, no done. A new start then yields a clean frame from 0x31.
